// File: rtl/acoustics_pkg.sv
// rtl/acoustics_pkg.sv - shared types and defaults for the acoustic frame scheduler
package acoustics_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int CH_W_DEF   = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN,
      ST_ACK
   } sched_state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [CH_W_DEF-1:0]   chan;
      logic                  last;
   } frame_entry_t;

endpackage

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module frame_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 128,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_q];
   assign count   = cnt_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

   // The scheduler's admission check is what keeps this from ever firing.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_b) !(push && full));

endmodule

// File: rtl/acoustic_frame_scheduler.sv
// rtl/acoustic_frame_scheduler.sv - round-robin frame readout from hydrophone ring buffers
module acoustic_frame_scheduler
   import acoustics_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FRAME_LEN  = 64,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 128,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_primed,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        send_frame,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [DATA_W-1:0]        m_data,
   output logic [CH_W-1:0]          m_chan,
   output logic                     m_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     busy
);

   localparam int EW      = DATA_W + CH_W + 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (FRAME_LEN > RD_LAT) ? FRAME_LEN : RD_LAT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   sched_state_t     state_q, state_d;
   logic [CH_W-1:0]  grant_q, grant_d;
   logic [CH_W-1:0]  rr_q, rr_d;
   logic [CH_W-1:0]  pick_idx;
   logic             pick_found;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RD_LAT-1:0] act_q, last_q;
   logic             act_in, last_in;
   logic [NUM_CH-1:0] eligible;
   logic [AW:0]      fifo_count;
   logic [AW+1:0]    free_slots;
   logic             fifo_empty;
   logic             push, pop;
   logic [EW-1:0]    push_entry, head_entry;

   assign eligible   = ch_req & ch_primed;
   assign pop        = m_valid & m_ready;
   assign free_slots = (AW+2)'(FIFO_DEPTH) - {1'b0, fifo_count} + (AW+2)'(pop);

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % NUM_CH;
         if (!pick_found && eligible[idx]) begin
            pick_found = 1'b1;
            pick_idx   = CH_W'(idx);
         end
      end
   end

   // cnt counts down the frame in STREAM, then is reused for the read-latency wait in DRAIN.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      ch_ack  = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found && (free_slots >= (AW+2)'(FRAME_LEN))) begin
               grant_d = pick_idx;
               cnt_d   = CW'(FRAME_LEN);
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (cnt_q == CW'(1)) begin
               cnt_d   = CW'(RD_LAT);
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CW'(1)) state_d = ST_ACK;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         ST_ACK: begin
            ch_ack  = NUM_CH'(1) << grant_q;
            rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Feeding the pipe from next-state lines the capture up with the buffer's read latency.
   assign act_in  = (state_d == ST_STREAM);
   assign last_in = act_in && (cnt_d == CW'(1));

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         act_q  <= '0;
         last_q <= '0;
      end else begin
         act_q[0]  <= act_in;
         last_q[0] <= last_in;
         for (int i = 1; i < RD_LAT; i++) begin
            act_q[i]  <= act_q[i-1];
            last_q[i] <= last_q[i-1];
         end
      end
   end

   assign push       = act_q[RD_LAT-1];
   assign push_entry = {ch_data[int'(grant_q)*DATA_W +: DATA_W], grant_q, last_q[RD_LAT-1]};

   frame_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (push),
      .din     (push_entry),
      .pop     (pop),
      .dout    (head_entry),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign send_frame = (state_q == ST_STREAM) ? (NUM_CH'(1) << grant_q) : '0;
   assign busy       = (state_q != ST_IDLE);
   assign m_valid    = ~fifo_empty;
   assign m_data     = m_valid ? head_entry[EW-1 -: DATA_W] : '0;
   assign m_chan     = m_valid ? head_entry[CH_W:1] : '0;
   assign m_last     = m_valid & head_entry[0];

endmodule

// File: tb/tb_acoustic_frame_scheduler.sv
// tb/tb_acoustic_frame_scheduler.sv - directed self-checking bench for acoustic_frame_scheduler
module tb_acoustic_frame_scheduler;

   localparam int NUM_CH     = 4;
   localparam int DATA_W     = 10;
   localparam int FRAME_LEN  = 64;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 128;

   logic        clk = 1'b0;
   logic        reset_b;
   logic [3:0]  ch_req, ch_primed, send_frame, ch_ack;
   logic [39:0] ch_data;
   logic [9:0]  m_data;
   logic [1:0]  m_chan;
   logic        m_last, m_valid, m_ready, busy;

   always #5 clk = ~clk;

   acoustic_frame_scheduler #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .FRAME_LEN  (FRAME_LEN),
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .ch_req     (ch_req),
      .ch_primed  (ch_primed),
      .ch_data    (ch_data),
      .send_frame (send_frame),
      .ch_ack     (ch_ack),
      .m_data     (m_data),
      .m_chan     (m_chan),
      .m_last     (m_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy)
   );

   // Ring buffer model: head reloads on each send_frame rise; sample k of channel c reads {c, k}.
   logic [NUM_CH-1:0][DATA_W-1:0] buf_q = '0;
   logic [7:0]                    k_q [NUM_CH] = '{default: 8'd0};
   logic [NUM_CH-1:0]             sf_prev_q = '0;

   always @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (send_frame[c]) begin
            buf_q[c] <= {2'(c), (sf_prev_q[c] ? k_q[c] : 8'd0)};
            k_q[c]   <= (sf_prev_q[c] ? k_q[c] : 8'd0) + 8'd1;
         end
      end
      sf_prev_q <= send_frame;
   end
   assign ch_data = buf_q;

   function automatic int oh2i(input logic [3:0] v);
      oh2i = -1;
      for (int i = 0; i < 4; i++) if (v[i]) oh2i = i;
   endfunction

   int          cyc = 0, rise_cyc = 0, ack_cyc = 0, mv_cyc = 0;
   int          cur_len = 0, gap = 0, overlap_cnt = 0, ack_total = 0;
   bit          had_fall = 1'b0;
   logic [3:0]  sf_n_prev = '0;
   logic        mv_prev = 1'b0;
   int          grant_seq[$], hi_len[$], gap_q[$], ack_q[$];
   logic [12:0] obs_q[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if ($countones(send_frame) > 1) overlap_cnt <= overlap_cnt + 1;
      if (send_frame != 4'b0) begin
         if (sf_n_prev == 4'b0) begin
            grant_seq.push_back(oh2i(send_frame));
            rise_cyc <= cyc;
            cur_len  <= 1;
            if (had_fall) gap_q.push_back(gap);
         end else begin
            cur_len <= cur_len + 1;
         end
      end else begin
         if (sf_n_prev != 4'b0) begin
            hi_len.push_back(cur_len);
            had_fall <= 1'b1;
            gap      <= 1;
         end else begin
            gap <= gap + 1;
         end
      end
      if (ch_ack != 4'b0) begin
         ack_q.push_back(oh2i(ch_ack));
         ack_cyc   <= cyc;
         ack_total <= ack_total + 1;
      end
      if (m_valid && !mv_prev) mv_cyc <= cyc;
      if (m_valid && m_ready) obs_q.push_back({m_data, m_chan, m_last});
      sf_n_prev <= send_frame;
      mv_prev   <= m_valid;
   end

   int n_assert = 0, n_fail = 0, rd_idx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int last_of(input int q[$]);
      last_of = (q.size() > 0) ? q[q.size()-1] : -1;
   endfunction

   task automatic check_frame(input string tag, input int ch);
      int bad = 0;
      for (int k = 0; k < FRAME_LEN; k++) begin
         logic [12:0] e;
         e = {2'(ch), 8'(k), 2'(ch), (k == FRAME_LEN - 1)};
         if (rd_idx >= obs_q.size()) bad++;
         else begin
            if (obs_q[rd_idx] !== e) bad++;
            rd_idx++;
         end
      end
      chk(tag, bad, 0);
   endtask

   task automatic wait_grants(input string tag, input int n, input int budget);
      int t = 0;
      while (grant_seq.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, (grant_seq.size() >= n), 1);
   endtask

   task automatic wait_acks(input string tag, input int n, input int budget);
      int t = 0;
      while (ack_total < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, (ack_total >= n), 1);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g, a, gap_base, ovl, min_gap;
      int exp_ord[5];
      exp_ord = '{0, 1, 2, 3, 0};
      ch_req = '0; ch_primed = '0; m_ready = 1'b0; reset_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_send_frame", send_frame, 0);
      chk("rst_ch_ack", ch_ack, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_chan", m_chan, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      drive_edge();
      reset_b = 1'b1;

      // Single channel, request dropped 10 cycles into the frame.
      drive_edge();
      ch_req = 4'b0001; ch_primed = 4'b0001; m_ready = 1'b1;
      wait_grants("t1_grant", 1, 20);
      chk("t1_grant_ch", last_of(grant_seq), 0);
      repeat (9) @(posedge clk);
      #1 ch_req = 4'b0000;
      wait_acks("t1_ack", 1, 200);
      repeat (8) @(negedge clk);
      chk("t1_ack_ch", last_of(ack_q), 0);
      chk("t1_sf_len", last_of(hi_len), FRAME_LEN);
      chk("t1_ack_latency", ack_cyc - rise_cyc, FRAME_LEN + RD_LAT);
      chk("t1_mvalid_latency", mv_cyc - rise_cyc, RD_LAT);
      check_frame("t1_frame", 0);
      chk("t1_no_extra", obs_q.size(), rd_idx);
      chk("t1_idle", busy, 0);

      // Unprimed channel is never granted; priming starts the frame next cycle.
      drive_edge();
      ch_req = 4'b0010; ch_primed = 4'b0000;
      g = grant_seq.size();
      repeat (20) @(negedge clk);
      chk("t3_unprimed_sf", send_frame, 0);
      chk("t3_unprimed_busy", busy, 0);
      chk("t3_no_grant", grant_seq.size(), g);
      drive_edge();
      ch_primed = 4'b0010;
      @(negedge clk);
      chk("t3_sf_decision_cycle", send_frame, 0);
      @(negedge clk);
      chk("t3_sf_next_cycle", send_frame, 4'b0010);
      drive_edge();
      ch_req = 4'b0000;
      wait_acks("t3_ack", 2, 200);
      repeat (8) @(negedge clk);
      chk("t3_ack_ch", last_of(ack_q), 1);
      check_frame("t3_frame", 1);

      // Reset in the middle of a channel-2 frame.
      drive_edge();
      ch_primed = 4'b1111; ch_req = 4'b0100;
      wait_grants("rs_grant", grant_seq.size() + 1, 20);
      chk("rs_grant_ch", last_of(grant_seq), 2);
      a = ack_total;
      repeat (20) @(negedge clk);
      #2 reset_b = 1'b0; ch_req = 4'b0000;
      #1;
      chk("rs_sf_async", send_frame, 0);
      chk("rs_mvalid", m_valid, 0);
      chk("rs_busy", busy, 0);
      chk("rs_rr_ptr", dut.rr_q, 0);
      repeat (3) @(posedge clk);
      #1 reset_b = 1'b1;
      rd_idx = obs_q.size();
      drive_edge();
      ch_req = 4'b1000;
      wait_grants("rs_post_grant", grant_seq.size() + 1, 20);
      chk("rs_post_grant_ch", last_of(grant_seq), 3);
      drive_edge();
      ch_req = 4'b0000;
      wait_acks("rs_post_ack", a + 1, 200);
      repeat (8) @(negedge clk);
      chk("rs_ack_count", ack_total - a, 1);
      chk("rs_ack_ch", last_of(ack_q), 3);
      check_frame("rs_frame", 3);

      // All four requesting: strict round-robin.
      g = grant_seq.size(); a = ack_total; gap_base = gap_q.size(); ovl = overlap_cnt;
      drive_edge();
      ch_req = 4'b1111;
      wait_grants("t2_grants", g + 5, 2000);
      drive_edge();
      ch_req = 4'b0000;
      wait_acks("t2_acks", a + 5, 300);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t2_order%0d", i), (grant_seq.size() > g + i) ? grant_seq[g + i] : -1, exp_ord[i]);
      min_gap = 1000;
      for (int i = gap_base + 1; i < gap_q.size(); i++)
         if (gap_q[i] < min_gap) min_gap = gap_q[i];
      chk("t2_gap_count", gap_q.size() - gap_base, 5);
      chk("t2_min_gap_ok", (min_gap >= RD_LAT + 2), 1);
      chk("t2_no_overlap", overlap_cnt - ovl, 0);
      for (int i = 0; i < 5; i++) check_frame($sformatf("t2_frame%0d", i), exp_ord[i]);

      // Stalled sink: only two frames fit; popping one frame's worth admits the third.
      g = grant_seq.size(); a = ack_total;
      drive_edge();
      m_ready = 1'b0; ch_req = 4'b0001;
      repeat (400) @(negedge clk);
      chk("t4_two_frames", grant_seq.size() - g, 2);
      chk("t4_withheld_busy", busy, 0);
      chk("t4_withheld_sf", send_frame, 0);
      chk("t4_mvalid", m_valid, 1);
      chk("t4_fifo_count", dut.fifo_count, FIFO_DEPTH);
      drive_edge();
      m_ready = 1'b1;
      repeat (64) @(posedge clk);
      #1 m_ready = 1'b0;
      wait_grants("t4_third_grant", g + 3, 50);
      drive_edge();
      ch_req = 4'b0000; m_ready = 1'b1;
      wait_acks("t4_acks", a + 3, 300);
      repeat (200) @(negedge clk);
      for (int i = 0; i < 3; i++) check_frame($sformatf("t4_frame%0d", i), 0);
      chk("t4_no_extra", obs_q.size(), rd_idx);
      chk("t4_drained", m_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/acoustic_frame_scheduler.md
# acoustic_frame_scheduler

Sequences frame readout from NUM_CH per-hydrophone ring buffers and shares the single downstream sample link between them. Round-robin grants one primed, requesting channel at a time; holds that buffer's send_frame high for exactly FRAME_LEN cycles; captures the returned samples after the RAM read latency; queues them, tagged, into an internal FIFO drained over a valid/ready stream. Sits between the channel ring buffers and the host serializer.

## Interface
- NUM_CH, 4, number of channel ring buffers
- DATA_W, 10, sample width
- FRAME_LEN, 64, samples per frame (≥2)
- RD_LAT, 2, cycles from the first send_frame-high edge to the first valid sample on ch_data
- FIFO_DEPTH, 128, output FIFO entries; power of 2, ≥ FRAME_LEN
- CH_W (localparam), max(1, clog2(NUM_CH))
---
- clk  in  1  clock
- reset_b  in  1  reset, asynchronous, active-low
- ch_req  in  NUM_CH  level request per channel: frame wanted
- ch_primed  in  NUM_CH  channel buffer has wrapped at least once (overflow seen); unprimed channels are never granted
- ch_data  in  NUM_CH*DATA_W  ring buffer read data, channel i at bits [i*DATA_W +: DATA_W]
- send_frame  out  NUM_CH  one-hot or zero; drives the granted buffer's Send_Frame
- ch_ack  out  NUM_CH  one-cycle pulse when a channel's frame is fully queued
- m_data  out  DATA_W  sample
- m_chan  out  CH_W  source channel of m_data
- m_last  out  1  final sample of a frame
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  downstream accepts when m_valid & m_ready
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, STREAM, DRAIN, ACK.
- IDLE: eligible = ch_req & ch_primed. If eligible ≠ 0 and FIFO free slots ≥ FRAME_LEN: grant = first eligible index scanning from rr_ptr upward modulo NUM_CH; load frame counter to FRAME_LEN; go STREAM.
- STREAM: send_frame[grant]=1; counter decrements each cycle; on counter==1 go DRAIN (send_frame high exactly FRAME_LEN cycles).
- DRAIN: send_frame=0; wait RD_LAT cycles, then go ACK.
- ACK: ch_ack[grant]=1 for one cycle; rr_ptr = grant+1 mod NUM_CH; go IDLE. Guarantees send_frame low ≥ RD_LAT+2 cycles between frames so the buffer reloads its head pointer.
- Capture: RD_LAT-deep shift register of (send_frame-active, last) bits; when its output is set, push {ch_data slice of grant, grant, last} into FIFO. last set only for the FRAME_LEN-th sample.
- Admission rule makes FIFO overflow impossible; push while full is an assertion failure.
- FIFO pop on m_valid & m_ready; m_data/m_chan/m_last show FIFO head, first-word-fall-through.
- ch_req dropping mid-frame does not abort; frame always completes with FRAME_LEN samples and ch_ack.
- m_ready held low never stalls STREAM; only blocks the next grant via the free-slot check.

## Timing
- Reset values: send_frame=0, ch_ack=0, m_valid=0, m_data=0, m_chan=0, m_last=0, busy=0, rr_ptr=0, FIFO empty, FSM IDLE, capture pipe cleared.
- Reset mid-frame: send_frame drops asynchronously; in-flight samples discarded; no ch_ack.
- Grant decision cycle T (IDLE): send_frame high T+1 … T+FRAME_LEN.
- First push at edge T+1+RD_LAT; last push at T+FRAME_LEN+RD_LAT; m_valid rises the cycle after the first push.
- ch_ack pulse at cycle T+FRAME_LEN+RD_LAT+1; next grant no earlier than the following cycle.
- Simultaneous requests: strict round-robin from rr_ptr; a continuously requesting channel waits at most NUM_CH−1 frames.
- Free-slot count uses the FIFO occupancy of the decision cycle, including a same-cycle pop.

## Structure
- Shared package acoustics_pkg: FSM state enum, DATA_W default, FIFO entry struct {data, chan, last}.
- One sub-module: frame_fifo (synchronous FWFT FIFO, parameterised width/depth, exports count).
- Round-robin pick, counter, capture pipe inline in acoustic_frame_scheduler.

## Test plan
- ch_req=0001, ch_primed=0001, m_ready=1, ch_data ramp → send_frame[0] high 64 cycles; 64 samples m_chan=0, m_last only on 64th; one ch_ack[0].
- ch_req=1111 all primed, m_ready=1 → grants 0,1,2,3,0 in order; no send_frame overlap; ≥ RD_LAT+2 low cycles between frames.
- ch_req=0010, ch_primed=0000 → send_frame stays 0, busy=0; assert ch_primed[1] → frame starts next cycle.
- m_ready=0, ch_req=0001 → exactly 2 frames queued (128 entries), third withheld; pop 64 → third grant issues.
- ch_req dropped after 10 cycles of STREAM → still 64 samples and ch_ack.
- reset_b low mid-STREAM → send_frame 0 immediately, m_valid 0, rr_ptr 0; post-reset ch_req=1000 grants channel 3 normally.
